// File: rtl/pc_ras_unit.sv
// Fetch-address generator: next-PC selection (redirect / return / jump / sequential)
// with a circular return-address stack supplying return targets.
module pc_ras_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                INC       = 4,
    parameter int                RAS_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         stall_i,
    input  logic                         redirect_valid_i,
    input  logic [ADDR_W-1:0]            redirect_pc_i,
    input  logic                         jump_valid_i,
    input  logic [ADDR_W-1:0]            jump_pc_i,
    input  logic                         call_i,
    input  logic [ADDR_W-1:0]            link_i,
    input  logic                         ret_i,
    output logic [ADDR_W-1:0]            pc_o,
    output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
    output logic                         ras_empty_o,
    output logic                         ret_miss_o
);

    localparam int                PTR_W = $clog2(RAS_DEPTH);
    localparam int                CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(RAS_DEPTH);
    localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  top;
    logic [PTR_W-1:0]  top_plus;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] top_entry;
    logic              ret_miss;
    logic              ret_miss_next;
    logic              accept;
    logic              ras_empty;
    logic              push;
    logic              replace;
    logic              pop;

    assign accept    = start_i & ~stall_i & ~redirect_valid_i;
    assign ras_empty = (count == '0);
    assign top_plus  = top + 1'b1;
    assign top_entry = ras_mem[top];

    // A call+return on an empty stack degenerates to a plain push.
    assign push    = accept & call_i & ~(ret_i & ~ras_empty);
    assign replace = accept & call_i & ret_i & ~ras_empty;
    assign pop     = accept & ret_i & ~call_i & ~ras_empty;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        pc_next       = pc;
        ret_miss_next = 1'b0;
        if (start_i) begin
            if (redirect_valid_i) begin
                pc_next = redirect_pc_i;
            end else if (!stall_i) begin
                if (ret_i && !ras_empty) begin
                    pc_next = top_entry;
                end else if (ret_i) begin
                    pc_next       = jump_pc_i;
                    ret_miss_next = 1'b1;
                end else if (jump_valid_i) begin
                    pc_next = jump_pc_i;
                end else begin
                    pc_next = pc + INC_V;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc       <= RESET_PC;
            top      <= '0;
            count    <= '0;
            ret_miss <= 1'b0;
        end else begin
            pc       <= pc_next;
            ret_miss <= ret_miss_next;
            if (push) begin
                top   <= top_plus;
                count <= (count == FULL) ? count : count + 1'b1;
            end else if (pop) begin
                top   <= top - 1'b1;
                count <= count - 1'b1;
            end
        end
    end

    // NOTE: the stack storage has no reset; entries are never read while count is zero.
    always_ff @(posedge clk_i) begin
        if (push) begin
            ras_mem[top_plus] <= link_i;
        end else if (replace) begin
            ras_mem[top] <= link_i;
        end
    end

    assign pc_o        = pc;
    assign ras_count_o = count;
    assign ras_empty_o = ras_empty;
    assign ret_miss_o  = ret_miss;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Self-checking bench for pc_ras_unit: directed vector table, async-reset sequence,
// then random traffic compared against a queue-based reference model.
module tb_pc_ras_unit;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        jump_valid_i = 1'b0;
    logic [31:0] jump_pc_i = '0;
    logic        call_i = 1'b0;
    logic [31:0] link_i = '0;
    logic        ret_i = 1'b0;
    logic [31:0] pc_o;
    logic [2:0]  ras_count_o;
    logic        ras_empty_o;
    logic        ret_miss_o;

    pc_ras_unit #(.ADDR_W(32), .RESET_PC(32'h0), .INC(4), .RAS_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .jump_valid_i(jump_valid_i), .jump_pc_i(jump_pc_i),
        .call_i(call_i), .link_i(link_i), .ret_i(ret_i),
        .pc_o(pc_o), .ras_count_o(ras_count_o), .ras_empty_o(ras_empty_o),
        .ret_miss_o(ret_miss_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        start, stall, redir;
        logic [31:0] rpc;
        logic        jv;
        logic [31:0] jpc;
        logic        call;
        logic [31:0] link;
        logic        ret;
        logic [31:0] exp_pc;
        int          exp_cnt;
        logic        exp_miss;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   total  = 0;

    // Reference model: the stack is a queue whose back is the top.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    logic        m_miss;

    function automatic vec_t v(input logic st, sl, rd, input logic [31:0] rp,
                               input logic jv, input logic [31:0] jp,
                               input logic cl, input logic [31:0] lk, input logic rt,
                               input logic [31:0] ep, input int ec, input logic em);
        vec_t r;
        r.start = st; r.stall = sl; r.redir = rd; r.rpc = rp;
        r.jv = jv; r.jpc = jp; r.call = cl; r.link = lk; r.ret = rt;
        r.exp_pc = ep; r.exp_cnt = ec; r.exp_miss = em;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'h0;
        m_q    = {};
        m_miss = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] npc;
        m_miss = 1'b0;
        if (!start_i) return;
        if (redirect_valid_i) begin
            m_pc = redirect_pc_i;
            return;
        end
        if (stall_i) return;
        if (ret_i && m_q.size() > 0) npc = m_q[$];
        else if (ret_i) begin npc = jump_pc_i; m_miss = 1'b1; end
        else if (jump_valid_i) npc = jump_pc_i;
        else npc = m_pc + 32'd4;
        if (call_i && ret_i) begin
            if (m_q.size() > 0) m_q[m_q.size()-1] = link_i;
            else m_q.push_back(link_i);
        end else if (call_i) begin
            m_q.push_back(link_i);
            if (m_q.size() > DEPTH) void'(m_q.pop_front());
        end else if (ret_i && m_q.size() > 0) begin
            void'(m_q.pop_back());
        end
        m_pc = npc;
    endtask

    task automatic drive(input vec_t x);
        start_i = x.start; stall_i = x.stall; redirect_valid_i = x.redir;
        redirect_pc_i = x.rpc; jump_valid_i = x.jv; jump_pc_i = x.jpc;
        call_i = x.call; link_i = x.link; ret_i = x.ret;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        drive(v(0,0,0,0,0,0,0,0,0,0,0,0));
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        // rd=redirect, jv=jump; fields: start stall redir rpc jv jpc call link ret | pc cnt miss
        vecs.push_back(v(0,0,0,0,      0,0,        0,0,   0, 32'h0,   0,0));
        vecs.push_back(v(1,0,0,0,      0,0,        0,0,   0, 32'h4,   0,0));
        vecs.push_back(v(1,0,0,0,      0,0,        0,0,   0, 32'h8,   0,0));
        vecs.push_back(v(1,0,0,0,      0,0,        0,0,   0, 32'hC,   0,0));
        vecs.push_back(v(1,0,1,32'h20, 0,0,        0,0,   0, 32'h20,  0,0));
        vecs.push_back(v(1,1,0,0,      0,0,        0,0,   0, 32'h20,  0,0));
        vecs.push_back(v(1,1,0,0,      0,0,        0,0,   0, 32'h20,  0,0));
        vecs.push_back(v(1,1,1,32'h100,0,0,        0,0,   0, 32'h100, 0,0));
        vecs.push_back(v(1,0,0,0,      1,32'h400,  1,32'h24,0, 32'h400, 1,0));
        vecs.push_back(v(1,0,0,0,      0,0,        0,0,   0, 32'h404, 1,0));
        vecs.push_back(v(1,0,0,0,      0,32'hDEAD0,0,0,   1, 32'h24,  0,0));
        vecs.push_back(v(1,0,0,0,      0,32'h200,  0,0,   1, 32'h200, 0,1));
        vecs.push_back(v(1,0,0,0,      0,0,        0,0,   0, 32'h204, 0,0));
        vecs.push_back(v(1,0,0,0,      0,0,        1,32'h10,0, 32'h208, 1,0));
        vecs.push_back(v(1,0,0,0,      0,0,        1,32'h20,0, 32'h20C, 2,0));
        vecs.push_back(v(1,0,0,0,      0,0,        1,32'h30,0, 32'h210, 3,0));
        vecs.push_back(v(1,0,0,0,      0,0,        1,32'h40,0, 32'h214, 4,0));
        vecs.push_back(v(1,0,0,0,      0,0,        1,32'h50,0, 32'h218, 4,0));
        vecs.push_back(v(1,0,0,0,      0,32'h600,  0,0,   1, 32'h50,  3,0));
        vecs.push_back(v(1,0,0,0,      0,32'h600,  0,0,   1, 32'h40,  2,0));
        vecs.push_back(v(1,0,0,0,      0,32'h600,  0,0,   1, 32'h30,  1,0));
        vecs.push_back(v(1,0,0,0,      0,32'h600,  0,0,   1, 32'h20,  0,0));
        vecs.push_back(v(1,0,0,0,      0,32'h600,  0,0,   1, 32'h600, 0,1));
        vecs.push_back(v(1,0,0,0,      0,0,        1,32'h10,0, 32'h604, 1,0));
        vecs.push_back(v(1,0,0,0,      0,0,        1,32'h20,0, 32'h608, 2,0));
        vecs.push_back(v(1,0,0,0,      0,0,        1,32'h30,0, 32'h60C, 3,0));
        vecs.push_back(v(1,0,0,0,      0,32'h700,  1,32'h90,1, 32'h30,  3,0));
        vecs.push_back(v(1,0,0,0,      0,0,        0,0,   1, 32'h90,  2,0));
        vecs.push_back(v(1,0,1,32'h800,0,0,        1,32'hAA,1, 32'h800, 2,0));
        vecs.push_back(v(1,0,0,0,      0,0,        0,0,   1, 32'h20,  1,0));
        vecs.push_back(v(0,0,0,0,      1,32'h44,   1,32'h55,1, 32'h20,  1,0));
        vecs.push_back(v(1,0,0,0,      0,0,        0,0,   1, 32'h10,  0,0));
        vecs.push_back(v(1,0,0,0,      0,32'h900,  1,32'hBB,1, 32'h900, 1,1));
        vecs.push_back(v(1,0,0,0,      0,0,        0,0,   1, 32'hBB,  0,0));
        vecs.push_back(v(1,1,0,0,      1,32'h44,   1,32'hCC,1, 32'hBB,  0,0));
        vecs.push_back(v(1,0,1,32'hFFFFFFFC,0,0,   0,0,   0, 32'hFFFFFFFC,0,0));
        vecs.push_back(v(1,0,0,0,      0,0,        0,0,   0, 32'h0,   0,0));

        // Reset state.
        model_reset();
        #12;
        check("reset pc", pc_o, 32'h0);
        check("reset count", 32'(ras_count_o), 32'd0);
        check("reset empty", 32'(ras_empty_o), 32'd1);
        check("reset miss", 32'(ret_miss_o), 32'd0);
        do_reset();

        foreach (vecs[i]) begin
            drive(vecs[i]);
            model_step();
            @(posedge clk_i);
            #1;
            check($sformatf("vec%0d pc", i), pc_o, vecs[i].exp_pc);
            check($sformatf("vec%0d count", i), 32'(ras_count_o), 32'(vecs[i].exp_cnt));
            check($sformatf("vec%0d empty", i), 32'(ras_empty_o), 32'(vecs[i].exp_cnt == 0));
            check($sformatf("vec%0d miss", i), 32'(ret_miss_o), 32'(vecs[i].exp_miss));
            @(negedge clk_i);
        end

        // Async reset asserted mid-stall, away from any clock edge.
        drive(v(1,0,0,0, 0,0, 1,32'h77,0, 0,0,0));
        @(posedge clk_i); #1;
        check("pre-reset pc", pc_o, 32'h4);
        check("pre-reset count", 32'(ras_count_o), 32'd1);
        @(negedge clk_i);
        drive(v(1,1,0,0, 0,0, 0,0,0, 0,0,0));
        @(posedge clk_i); #1;
        check("stall hold pc", pc_o, 32'h4);
        #2;
        rst_i = 1'b1;
        #1;
        check("async reset pc", pc_o, 32'h0);
        check("async reset count", 32'(ras_count_o), 32'd0);
        check("async reset empty", 32'(ras_empty_o), 32'd1);
        do_reset();

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            start_i          = ($urandom_range(0, 9) != 0);
            stall_i          = ($urandom_range(0, 6) == 0);
            redirect_valid_i = ($urandom_range(0, 9) == 0);
            redirect_pc_i    = $urandom & 32'hFFFF_FFFC;
            jump_valid_i     = ($urandom_range(0, 3) == 0);
            jump_pc_i        = $urandom & 32'hFFFF_FFFC;
            call_i           = ($urandom_range(0, 2) == 0);
            link_i           = $urandom & 32'hFFFF_FFFC;
            ret_i            = ($urandom_range(0, 2) == 0);
            model_step();
            @(posedge clk_i);
            #1;
            check($sformatf("rand%0d pc", n), pc_o, m_pc);
            check($sformatf("rand%0d count", n), 32'(ras_count_o), 32'(m_q.size()));
            check($sformatf("rand%0d miss", n), 32'(ret_miss_o), 32'(m_miss));
            @(negedge clk_i);
        end

        $display("Result: errors=%0d of %0d checks", errors, total);
        $finish;
    end

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
Parametrised fetch-address generator and the next-generation PC register for the pipeline CPU. It selects the next fetch address from EX-stage redirect, ID-stage jump/return, or sequential increment, and supports stall and start gating. A circular return-address stack (RAS) supplies return targets for call/return pairs without waiting for register read.

Parameters:
ADDR_W, 32, width of PC and all address ports
RESET_PC, 0, value loaded into pc_o on reset
INC, 4, sequential increment added to pc_o
RAS_DEPTH, 4, RAS entries; power of 2, minimum 2

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous active-high reset
start_i  input  1  run enable; 0 freezes all state
stall_i  input  1  hazard stall; hold PC, ignore ID-stage requests
redirect_valid_i  input  1  EX-stage branch/mispredict redirect
redirect_pc_i  input  ADDR_W  redirect target
jump_valid_i  input  1  ID-stage jump (includes calls)
jump_pc_i  input  ADDR_W  jump target; fallback target for ret_i on empty RAS
call_i  input  1  ID instruction is a call; push link_i
link_i  input  ADDR_W  return address to push
ret_i  input  1  ID instruction is a return; pop RAS
pc_o  output  ADDR_W  current fetch address
ras_count_o  output  clog2(RAS_DEPTH)+1  valid RAS entries
ras_empty_o  output  1  ras_count_o == 0
ret_miss_o  output  1  registered pulse: ret_i accepted with empty RAS

Behaviour:
- Reset (async, rst_i=1): pc_o=RESET_PC, RAS pointer=0, ras_count_o=0, ras_empty_o=1, ret_miss_o=0. RAS storage contents undefined, not read while empty.
- "accept" = start_i & ~stall_i & ~redirect_valid_i. ID requests (jump_valid_i, call_i, ret_i) act only when accept=1.
- Next-PC priority, evaluated each rising edge:
  1. start_i=0: hold pc_o, no RAS change, ret_miss_o=0.
  2. redirect_valid_i=1: pc_o<=redirect_pc_i (overrides stall_i); RAS unchanged.
  3. stall_i=1: hold pc_o; RAS unchanged.
  4. ret_i with RAS non-empty: pc_o<=RAS top.
  5. ret_i with RAS empty: pc_o<=jump_pc_i; ret_miss_o<=1 for one cycle.
  6. jump_valid_i: pc_o<=jump_pc_i.
  7. otherwise pc_o<=pc_o+INC, modulo 2^ADDR_W (wraps silently).
- ret_miss_o is 0 in every cycle not covered by rule 5.
- RAS is a circular buffer with top pointer; updates only when accept=1:
  - call_i only: write link_i at top+1, top<=top+1, count<=min(count+1, RAS_DEPTH). Push when full overwrites the oldest entry; count saturates.
  - ret_i only: non-empty: top<=top-1, count<=count-1. Empty: no change.
  - call_i & ret_i together: replace top entry with link_i; pointer and count unchanged. pc_o follows rule 4, using the pre-replace top. If the RAS is empty, push link_i (count=1) and apply rule 5.
- call_i without jump_valid_i still pushes. The PC follows rule 6 or 7.
- Latency: every selection is visible on pc_o one cycle after the edge. There is no combinational path from inputs to pc_o.
- Reset asserted mid-operation discards all pending requests immediately.

Test Plan:
- Reset, then start_i=1 with no requests for 3 cycles -> pc_o 0,4,8,12; ras_empty_o=1.
- pc_o=0x20, stall_i=1 for 2 cycles, then redirect_valid_i=1 with redirect_pc_i=0x100 while stall_i still 1 -> pc_o holds 0x20,0x20 and the redirect wins: pc_o=0x100 next cycle.
- call_i with jump_valid_i, jump_pc_i=0x400, link_i=0x24; later ret_i -> pc_o=0x400, then 0x24; ras_count_o 1 then 0.
- RAS_DEPTH=4: push links 0x10,0x20,0x30,0x40,0x50, then 5 returns -> targets 0x50,0x40,0x30,0x20; 5th return uses jump_pc_i with ret_miss_o=1; count 4,3,2,1,0,0.
- call_i & ret_i together with top=0x30 and link_i=0x90 -> pc_o=0x30, count unchanged, next ret -> pc_o=0x90. Same request with redirect_valid_i=1 -> pc_o=redirect_pc_i and RAS untouched.
- ADDR_W=32, pc_o=0xFFFFFFFC sequential -> pc_o=0x0. Assert rst_i mid-stall -> pc_o=RESET_PC asynchronously and count=0.
